// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle sequencer and HI/LO register pair around the combinational MulDiv block
module hilo_unit #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [1:0]  opIn,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        mtHi,
  input  logic        mtLo,
  input  logic [31:0] mtData,
  input  logic        rdHi,
  input  logic        rdLo,
  input  logic        flush,
  output logic [1:0]  mdOp,
  output logic [31:0] din1,
  output logic [31:0] din2,
  input  logic [31:0] doutHi,
  input  logic [31:0] doutLo,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        busy,
  output logic        stall,
  output logic        done
);
  typedef enum logic {IDLE, BUSY} stateT;
  stateT state, nextState;
  logic [3:0] cnt;
  logic accept, commit, mtOk;
  always_comb begin
    nextState = state;
    accept = 1'b0;
    commit = 1'b0;
    mtOk = 1'b0;
    if (state == IDLE) begin
      mtOk = !flush;
      accept = start && !flush;
      nextState = accept ? BUSY : IDLE;
    end else begin
      commit = !flush && cnt == 4'd0;
      nextState = (flush || commit) ? IDLE : BUSY;
    end
  end
  assign busy = state == BUSY;
  assign stall = busy & (start | rdHi | rdLo | mtHi | mtLo);
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state <= IDLE;
    else state <= nextState;
  // counter holds the remaining edges minus one, so commit fires on the edge it reads zero
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
      mdOp <= '0;
      din1 <= '0;
      din2 <= '0;
      hiOut <= '0;
      loOut <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        mdOp <= opIn;
        din1 <= srcA;
        din2 <= srcB;
      end else if (busy && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        hiOut <= doutHi;
        loOut <= doutLo;
      end else begin
        if (mtOk && mtHi) hiOut <= mtData;
        if (mtOk && mtLo) loOut <= mtData;
      end
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed plus random checks of hilo_unit against a transaction-level HI/LO model
module tb_hilo_unit;
  localparam int LATENCY = 4;
  logic clk = 0, rstN = 0, start = 0, mtHi = 0, mtLo = 0, rdHi = 0, rdLo = 0, flush = 0;
  logic [1:0] opIn = 0, mdOp;
  logic [31:0] srcA = 0, srcB = 0, mtData = 0, din1, din2, doutHi, doutLo, hiOut, loOut;
  logic busy, stall, done;
  int nChecks = 0, nErrors = 0;
  bit mBusy, mDone;
  int mLeft;
  logic [1:0] mOp;
  logic [31:0] mA, mB, mHi, mLo;

  hilo_unit #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rstN(rstN), .start(start), .opIn(opIn), .srcA(srcA), .srcB(srcB),
    .mtHi(mtHi), .mtLo(mtLo), .mtData(mtData), .rdHi(rdHi), .rdLo(rdLo), .flush(flush),
    .mdOp(mdOp), .din1(din1), .din2(din2), .doutHi(doutHi), .doutLo(doutLo),
    .hiOut(hiOut), .loOut(loOut), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    case (op)
      2'b00: begin
        if (b == 0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      2'b01: return (b == 0) ? 64'd0 : {a % b, a / b};
      2'b10: return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      default: return {32'd0, a} * {32'd0, b};
    endcase
  endfunction

  assign {doutHi, doutLo} = mulDiv(mdOp, din1, din2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mDone = 0; mLeft = 0; mOp = 0; mA = 0; mB = 0; mHi = 0; mLo = 0;
  endtask

  task automatic idle();
    start = 0; mtHi = 0; mtLo = 0; rdHi = 0; rdLo = 0; flush = 0;
  endtask

  // one clock: check stall before the edge, advance the model, check registered state after it
  task automatic step();
    #1;
    check("stall", stall, mBusy & (start | rdHi | rdLo | mtHi | mtLo));
    @(posedge clk);
    mDone = 0;
    if (mBusy) begin
      if (flush) mBusy = 0;
      else if (mLeft == 1) begin
        {mHi, mLo} = mulDiv(mOp, mA, mB);
        mBusy = 0;
        mDone = 1;
      end else mLeft--;
    end else if (!flush) begin
      if (mtHi) mHi = mtData;
      if (mtLo) mLo = mtData;
      if (start) begin mBusy = 1; mLeft = LATENCY; mOp = opIn; mA = srcA; mB = srcB; end
    end
    #1;
    check("busy", busy, mBusy);
    check("done", done, mDone);
    check("hi", hiOut, mHi);
    check("lo", loOut, mLo);
    check("mdOp", mdOp, mOp);
    check("din1", din1, mA);
    check("din2", din2, mB);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1; opIn = op; srcA = a; srcB = b;
    step();
    start = 0;
  endtask

  initial begin
    int n;
    modelReset();
    #12;
    check("rstBusy", busy, 0);
    check("rstHi", hiOut, 0);
    check("rstLo", loOut, 0);
    check("rstDin", {din1, din2}, 0);
    check("rstOp", mdOp, 0);
    check("rstDone", done, 0);
    rstN = 1;
    step();

    issue(2'b10, 32'hFFFF_FFFD, 32'd5);
    repeat (3) step();
    check("t1BusyHeld", busy, 1);
    step();
    check("t1Hi", hiOut, 32'hFFFF_FFFF);
    check("t1Lo", loOut, 32'hFFFF_FFF1);
    check("t1Done", done, 1);
    step();
    check("t1DoneOnce", done, 0);

    issue(2'b01, 32'd100, 32'd7);
    start = 1; opIn = 2'b00; srcA = 32'hFFFF_FFF9; srcB = 32'd2;
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    check("t2Bound", n < 20, 1);
    check("t2Hi1", hiOut, 32'd2);
    check("t2Lo1", loOut, 32'd14);
    step();
    check("t2Accept", busy, 1);
    start = 0;
    repeat (4) step();
    check("t2Hi2", hiOut, 32'hFFFF_FFFF);
    check("t2Lo2", loOut, 32'hFFFF_FFFD);

    issue(2'b11, 32'hFFFF_FFFF, 32'd2);
    rdHi = 1;
    #1 check("t3Stall", stall, 1);
    repeat (4) step();
    #1 check("t3Release", stall, 0);
    check("t3Hi", hiOut, 32'd1);
    check("t3Lo", loOut, 32'hFFFF_FFFE);
    idle();

    mtHi = 1; mtData = 32'h1234_5678; step();
    mtHi = 0; mtLo = 1; mtData = 32'h9ABC_DEF0; step();
    check("t4Hi", hiOut, 32'h1234_5678);
    check("t4Lo", loOut, 32'h9ABC_DEF0);
    mtHi = 1; mtLo = 1; mtData = 32'h5555_AAAA; step();
    check("t4Both", {hiOut, loOut}, {2{32'h5555_AAAA}});
    idle();
    issue(2'b10, 32'd3, 32'd3);
    mtHi = 1; mtLo = 1; mtData = 32'hDEAD_BEEF;
    repeat (4) step();
    check("t4Commit", {hiOut, loOut}, {32'd0, 32'd9});
    step();
    check("t4Retry", {hiOut, loOut}, {2{32'hDEAD_BEEF}});
    idle();

    mtHi = 1; mtData = 32'h1111_1111; step();
    mtHi = 0; mtLo = 1; mtData = 32'h2222_2222; step();
    idle();
    issue(2'b10, 32'd9, 32'd9);
    step();
    flush = 1; step(); flush = 0;
    check("t5Idle", busy, 0);
    check("t5Keep", {hiOut, loOut}, {32'h1111_1111, 32'h2222_2222});
    step();
    check("t5NoDone", done, 0);
    issue(2'b10, 32'd9, 32'd9);
    repeat (3) step();
    flush = 1; step(); flush = 0;
    check("t5CommitBlocked", {hiOut, loOut}, {32'h1111_1111, 32'h2222_2222});
    step();
    check("t5NoDone2", done, 0);

    issue(2'b10, 32'd123, 32'd456);
    step();
    #3 rstN = 0;
    #1;
    check("t6Busy", busy, 0);
    check("t6HiLo", {hiOut, loOut}, 0);
    check("t6Din", {din1, din2}, 0);
    modelReset();
    #2 rstN = 1;
    issue(2'b10, 32'd6, 32'd7);
    repeat (4) step();
    check("t6Hi", hiOut, 0);
    check("t6Lo", loOut, 32'h2A);

    for (int i = 0; i < 400; i++) begin
      start = $urandom_range(2) == 0;
      opIn = 2'($urandom);
      srcA = $urandom;
      srcB = ($urandom_range(3) == 0) ? 32'($urandom_range(9)) : $urandom;
      mtHi = $urandom_range(5) == 0;
      mtLo = $urandom_range(5) == 0;
      mtData = $urandom;
      rdHi = $urandom_range(3) == 0;
      rdLo = $urandom_range(3) == 0;
      flush = $urandom_range(19) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
